fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- PC generation and instruction fetch front end.
- Drives the byte address into the asynchronous-read instruction ROM and captures the returned word with its PC in a small fetch queue.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution, the fetch enable, and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FQ_DEPTH, 2, fetch queue entries; power of 2, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- fetch_en  input  1  1 = fetch allowed; 0 = hold PC, issue nothing.
- redirect_valid  input  1  one-cycle request to load a new PC and flush the queue.
- redirect_pc  input  ALEN  target byte address.
- imem_addr  output  ALEN  byte address to the instruction ROM; equals the PC register.
- imem_en  output  1  high in cycles where a fetch is issued.
- imem_instr  input  XLEN  combinational ROM data for imem_addr, same cycle.
- id_valid  output  1  queue head holds a valid instruction.
- id_ready  input  1  decode accepts the head this cycle.
- id_pc  output  ALEN  PC of the head entry.
- id_instr  output  XLEN  instruction of the head entry.
- fetch_fault  output  1  misaligned redirect target; held while in FAULT.

Behaviour:
- Reset (rst = 0, async): pc = RESET_PC, queue count = 0, rd/wr ptr = 0, state = BOOT.
  - Outputs during reset: id_valid = 0, imem_en = 0, fetch_fault = 0.
  - id_pc and id_instr = 0 when the queue is empty.
- States:
  - BOOT -> RUN after exactly one clock with rst high; no fetch in BOOT.
  - RUN -> STALL when fetch_en = 0; STALL -> RUN when fetch_en = 1.
  - Any state -> FAULT on a redirect with redirect_pc[1:0] != 0.
  - FAULT -> RUN (or STALL if fetch_en = 0) only on a redirect with an aligned target.
- Fetch issue:
  - imem_en = (state == RUN) && !redirect_valid && (!full || deq), where deq = id_valid && id_ready.
  - On issue: push {pc, imem_instr} at the tail, then pc <= pc + 4.
  - PC arithmetic wraps modulo 2^ALEN.
- Latency: instruction fetched in cycle N is visible on id_valid/id_pc/id_instr in cycle N+1. The queue output is registered from storage; there is no combinational path from imem_instr to id_*.
- Handshake:
  - id_pc and id_instr are stable while id_valid = 1 and id_ready = 0.
  - The head is popped on deq. id_ready is ignored when id_valid = 0.
- Simultaneous push and pop when full: both occur and count is unchanged, so full throughput is 1 instr/cycle.
- Redirect has highest priority, in the same cycle:
  - Queue flushes: count = 0 and ptrs reset; any deq that cycle is discarded.
  - No push; pc <= redirect_pc.
  - id_valid = 0 in cycle R+1; target instruction issued in R+1 and visible in R+2.
- Misaligned redirect:
  - pc <= {redirect_pc[ALEN-1:2], 2'b00}, queue flushes, state = FAULT, fetch_fault = 1 from the next cycle.
  - No fetch is issued while in FAULT.
- fetch_en = 0: an issue already in flight this cycle completes, since fetch_en is sampled for the next-state decision. Then the PC holds. Queued entries still drain to decode.
- Redirect in BOOT or STALL: the PC loads, the queue flushes, and the state machine rules above apply.
- Reset mid-operation: immediate return to the reset values; queue contents are lost.
- imem_addr = pc at all times, even when imem_en = 0.

Test Plan:
- Reset release with id_ready = 1, ROM words 0..3 = A,B,C,D:
  - Required: BOOT for 1 cycle, then imem_addr = 0,4,8,12 on consecutive cycles.
  - Required: id_pc = 0,4,8 with id_instr = A,B,C starting the cycle after the first fetch.
- Backpressure, id_ready = 0 for 5 cycles:
  - Required: exactly FQ_DEPTH = 2 entries fill, imem_en drops, pc holds at 8, id_pc = 0 stable.
  - Then id_ready = 1: required drain 0,4,8 with no gaps and no duplicates.
- Redirect to 0x40 while the queue holds 2 entries:
  - Required: id_valid = 0 next cycle.
  - Required: the cycle after, id_pc = 0x40; no stale PC (4 or 8) ever delivered.
- Redirect to 0x42:
  - Required: fetch_fault = 1 next cycle, imem_en = 0, id_valid = 0 until recovery.
  - Then a redirect to 0x80: required fetch_fault = 0 and fetch resumes at 0x80.
- fetch_en = 0 for 3 cycles mid-stream:
  - Required: pc frozen, queued entries still delivered, fetch resumes at the next sequential PC.
- Wrap-around with redirect to 0xFFFF_FFFC:
  - Required: next fetch address = 0x0000_0000.
- Async reset mid-stream:
  - Required: id_valid = 0 and pc = RESET_PC without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// PC generation and instruction fetch front end: drives the async-read ROM and buffers
// {pc, instr} in a small queue that decode drains over a valid/ready handshake.
module fetch_stage #(
  parameter int unsigned     ALEN     = 32,
  parameter int unsigned     XLEN     = 32,
  parameter logic [ALEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [ALEN-1:0] redirect_pc,
  output logic [ALEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [XLEN-1:0] imem_instr,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ALEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            fetch_fault
);

  localparam int unsigned PtrW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

  typedef enum logic [1:0] {StBoot, StRun, StStall, StFault} state_e;

  state_e          state_q, state_d;
  logic [ALEN-1:0] pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [ALEN-1:0] pc_mem_q    [FQ_DEPTH];
  logic [XLEN-1:0] instr_mem_q [FQ_DEPTH];

  logic full, deq, issue, misaligned;

  always_comb begin
    full       = (count_q == CntW'(FQ_DEPTH));
    id_valid   = (count_q != '0);
    deq        = id_valid && id_ready;
    issue      = (state_q == StRun) && !redirect_valid && (!full || deq);
    misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    imem_en     = issue;
    imem_addr   = pc_q;
    fetch_fault = (state_q == StFault);
    id_pc       = id_valid ? pc_mem_q[rd_ptr_q]    : '0;
    id_instr    = id_valid ? instr_mem_q[rd_ptr_q] : '0;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    unique case (state_q)
      StBoot:         state_d = StRun;
      StRun, StStall: state_d = fetch_en ? StRun : StStall;
      StFault:        state_d = StFault;
      default:        state_d = StBoot;
    endcase

    if (redirect_valid) begin
      // Flush wins over any same-cycle push or pop; low bits dropped for misaligned targets.
      pc_d     = {redirect_pc[ALEN-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (misaligned) begin
        state_d = StFault;
      end else if (state_q == StFault) begin
        state_d = fetch_en ? StRun : StStall;
      end
    end else begin
      if (issue) begin
        pc_d     = pc_q + ALEN'(4);
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({issue, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected deliveries into a scoreboard
// queue, a negedge monitor pops and compares every accepted decode handshake.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        fetch_fault;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q [$];

  localparam logic [31:0] RomA = 32'h1111_0A0A;
  localparam logic [31:0] RomB = 32'h2222_0B0B;
  localparam logic [31:0] RomC = 32'h3333_0C0C;
  localparam logic [31:0] RomD = 32'h4444_0D0D;

  fetch_stage #(
    .ALEN    (32),
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .FQ_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .imem_instr    (imem_instr),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   return RomA;
      32'h4:   return RomB;
      32'h8:   return RomC;
      32'hC:   return RomD;
      default: return a ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  always_comb imem_instr = rom(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive just after the rising edge, return at the falling edge for sampling.
  task automatic cyc(input logic rdy, input logic fen, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    id_ready       = rdy;
    fetch_en       = fen;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  // Scoreboard monitor; accepts during a redirect cycle are discarded by the DUT.
  always @(negedge clk) begin
    if (rst && id_valid && id_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", id_pc, 32'hXXXX_XXXX);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("deliver_pc", id_pc, e);
        check("deliver_instr", id_instr, rom(e));
      end
    end
  end

  initial begin
    rst = 1'b0; fetch_en = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8, 32'h40,
              32'h80, 32'h84, 32'h88, 32'h8C, 32'hFFFF_FFFC, 32'h0};

    #3;
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_imem_en", {31'b0, imem_en}, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_instr", id_instr, 32'h0);

    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("boot_en", {31'b0, imem_en}, 32'd0);

    // Sequential fetch 0,4,8,12; decode takes 0,4,8.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      check("seq_addr", imem_addr, 32'(i * 4));
      check("seq_en", {31'b0, imem_en}, 32'd1);
    end

    // Redirect to 0 with decode stalled, then backpressure fills the queue.
    cyc(1'b0, 1'b1, 1'b1, 32'h0);
    check("redir_en", {31'b0, imem_en}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_valid0", {31'b0, id_valid}, 32'd0);
    check("bp_addr0", imem_addr, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("bp_en1", {31'b0, imem_en}, 32'd1);
    check("bp_addr1", imem_addr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      check("bp_full_en", {31'b0, imem_en}, 32'd0);
      check("bp_hold_addr", imem_addr, 32'h8);
      check("bp_hold_pc", id_pc, 32'h0);
      check("bp_hold_instr", id_instr, RomA);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      check("drain_en", {31'b0, imem_en}, 32'd1);
    end

    // Redirect to 0x40 with a full queue; same-cycle accept is dropped.
    cyc(1'b1, 1'b1, 1'b1, 32'h40);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("r40_valid", {31'b0, id_valid}, 32'd0);
    check("r40_addr", imem_addr, 32'h40);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("r40_id_pc", id_pc, 32'h40);

    // Misaligned redirect, then recovery to 0x80.
    cyc(1'b1, 1'b1, 1'b1, 32'h42);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("flt_fault", {31'b0, fetch_fault}, 32'd1);
    check("flt_en", {31'b0, imem_en}, 32'd0);
    check("flt_valid", {31'b0, id_valid}, 32'd0);
    check("flt_addr", imem_addr, 32'h40);
    cyc(1'b1, 1'b1, 1'b1, 32'h80);
    check("flt_hold", {31'b0, fetch_fault}, 32'd1);
    check("flt_valid2", {31'b0, id_valid}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("rec_fault", {31'b0, fetch_fault}, 32'd0);
    check("rec_en", {31'b0, imem_en}, 32'd1);
    check("rec_addr", imem_addr, 32'h80);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);

    // fetch_en low for three cycles: in-flight issue completes, then PC freezes.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("fen_inflight_en", {31'b0, imem_en}, 32'd1);
    check("fen_inflight_addr", imem_addr, 32'h88);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      check("fen_hold_addr", imem_addr, 32'h8C);
      check("fen_hold_en", {31'b0, imem_en}, 32'd0);
    end
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("fen_stall_en", {31'b0, imem_en}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("fen_resume_en", {31'b0, imem_en}, 32'd1);
    check("fen_resume_addr", imem_addr, 32'h8C);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);

    // Wrap-around.
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr1", imem_addr, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr2", imem_addr, 32'h4);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b0;
    #1;
    check("arst_valid", {31'b0, id_valid}, 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_en", {31'b0, imem_en}, 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
